mult_div_unit: RTL
==================

# mult_div_unit

Sequential signed multiply/divide responder for the multicycle MIPS datapath. The control FSM pulses `mult_start` or `div_start` with operands `rs`/`rt`. This block iterates one bit per cycle, writes HI/LO, and returns a one-cycle `mult_done`/`div_done` that the FSM waits on. It also flags divide-by-zero so the FSM can raise exception code 3'b010 and vector to the handler.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each WIDTH bits.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mult_start`  in  1  one-cycle request: signed `a*b`.
- `div_start`  in  1  one-cycle request: signed `a/b`.
- `a`  in  WIDTH  dividend / multiplicand (rs), sampled with start.
- `b`  in  WIDTH  divisor / multiplier (rt), sampled with start.
- `hi`  out  WIDTH  product[63:32] or remainder.
- `lo`  out  WIDTH  product[31:0] or quotient.
- `mult_done`  out  1  one-cycle pulse when a multiply completes.
- `div_done`  out  1  one-cycle pulse when a divide completes or is aborted.
- `div_by_zero`  out  1  high with `div_done` when `b` was 0.
- `busy`  out  1  high from the cycle after a start is accepted through the done cycle.

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- IDLE:
  - `mult_start` → latch operands, counter=WIDTH, go to MUL_RUN.
  - `div_start` with `b`≠0 → latch |a|, |b| and both signs, go to DIV_RUN.
  - `div_start` with `b`==0 → go to DONE with the zero flag set; no arithmetic is performed.
- Both starts high at once: multiply wins, `div_start` is ignored.
- Starts outside IDLE are ignored. No queueing.
- MUL_RUN: radix-2 Booth on a {acc, multiplier, q-1} register, one step per cycle, WIDTH cycles, then DONE.
- DIV_RUN: restoring division on unsigned magnitudes, one quotient bit per cycle, WIDTH cycles, then DIV_FIX.
- DIV_FIX: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncate toward zero). Then DONE.
- DONE:
  - Update `hi`/`lo` on entry.
  - Assert exactly one of `mult_done`/`div_done` for one cycle, then return to IDLE.
- Divide-by-zero: `hi`/`lo` keep their previous values; `div_by_zero`=1 with `div_done`.
- −2^31 / −1: quotient wraps to 0x80000000, remainder 0. No flag.
- `hi`/`lo` hold their value between operations and are not touched by ignored starts.
- Reset, asynchronous, including mid-operation:
  - state=IDLE, counter=0.
  - `hi`=`lo`=0, `mult_done`=`div_done`=`div_by_zero`=`busy`=0.
  - Any operation in flight is discarded.

## Timing
- The start is sampled at edge E0.
- Multiply: `hi`/`lo` valid and `mult_done`=1 in the cycle after edge E(WIDTH+1). That is 33 cycles for WIDTH=32.
- Divide: `div_done`=1 in the cycle after edge E(WIDTH+2). That is 34 cycles.
- Divide-by-zero: `div_done`=`div_by_zero`=1 in the cycle after E1.
- `busy` rises in the cycle after E0 and falls in the cycle after the done pulse.
- A new start is accepted in the cycle after the done cycle, so back-to-back operations have a 1-cycle gap minimum.
- `done` and `div_by_zero` are registered outputs, with no combinational path from the inputs.

## Structure
- Shared package `cpu_pkg`:
  - `WIDTH`.
  - The `md_state_t` enum (IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE).
  - Exception code constant `EXC_DIV0 = 3'b010`, used by the control FSM.
- Single module, no sub-module.
- Multiply and divide share one iteration counter ($clog2(WIDTH)+1 bits) and one 2·WIDTH+1-bit working register.

## Test plan
- mult 7 × −3 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `mult_done` pulses exactly 33 cycles after start; `busy` high throughout.
- mult 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- div 7 / −2 → `lo`=0xFFFFFFFD, `hi`=1.
- div −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Both divides pulse `div_done` at cycle 34.
- div −2^31 / −1 → `lo`=0x80000000, `hi`=0.
- Preload `hi`/`lo` via mult 3×5, then div 9/0:
  - `div_done`=`div_by_zero`=1 one cycle later.
  - `hi`=0, `lo`=15 unchanged.
- Reset and overlap:
  - `div_start` at cycle 10 of a multiply → ignored; the multiply result is correct.
  - Both starts in the same cycle → multiply performed.
  - Async reset at cycle 20 → all outputs 0 immediately; the next mult 2×2 gives `lo`=4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath definitions: operand width, multiply/divide unit states and
// the divide-by-zero exception code raised by the control FSM.
package cpu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_RUN = 3'd1,
    DIV_RUN = 3'd2,
    DIV_FIX = 3'd3,
    DONE    = 3'd4
  } md_state_t;

  localparam logic [2:0] EXC_DIV0 = 3'b010;

endpackage

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit writing
// HI/LO, one bit per cycle, with a registered done pulse and divide-by-zero flag.
module mult_div_unit
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_done,
  output logic             div_done,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned RW = 2 * WIDTH + 1;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    work_q, work_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic             is_div_q, is_div_d, zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             mult_done_q, mult_done_d, div_done_q, div_done_d;
  logic             dz_q, dz_d, busy_q, busy_d;

  logic [WIDTH:0]   booth_acc, booth_m, booth_sum;
  logic [RW-1:0]    div_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mag_a, mag_b, fix_q, fix_r;

  // Datapath helpers; the Booth add is one bit wider so the most negative
  // multiplicand cannot overflow the accumulator before the shift.
  always_comb begin
    booth_acc = {work_q[RW-1], work_q[RW-1:WIDTH+1]};
    booth_m   = {opnd_q[WIDTH-1], opnd_q};
    unique case (work_q[1:0])
      2'b01:   booth_sum = booth_acc + booth_m;
      2'b10:   booth_sum = booth_acc - booth_m;
      default: booth_sum = booth_acc;
    endcase
    div_shift = work_q << 1;
    trial     = div_shift[RW-1:WIDTH] - {1'b0, opnd_q};
    mag_a     = a[WIDTH-1] ? -a : a;
    mag_b     = b[WIDTH-1] ? -b : b;
    fix_q     = (sign_a_q ^ sign_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    fix_r     = sign_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    opnd_d      = opnd_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    is_div_d    = is_div_q;
    zero_d      = zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mult_done_d = 1'b0;
    div_done_d  = 1'b0;
    dz_d        = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        // busy_q still set here means this is the done cycle: starts ignored
        busy_d = 1'b0;
        if (!busy_q && mult_start) begin
          work_d   = {WIDTH'(0), a, 1'b0};
          opnd_d   = b;
          cnt_d    = CNT_W'(WIDTH);
          is_div_d = 1'b0;
          zero_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = MUL_RUN;
        end else if (!busy_q && div_start) begin
          is_div_d = 1'b1;
          busy_d   = 1'b1;
          if (b == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d   = 1'b0;
            work_d   = {(WIDTH + 1)'(0), mag_a};
            opnd_d   = mag_b;
            sign_a_d = a[WIDTH-1];
            sign_b_d = b[WIDTH-1];
            cnt_d    = CNT_W'(WIDTH);
            state_d  = DIV_RUN;
          end
        end
      end
      MUL_RUN: begin
        work_d = {booth_sum, work_q[WIDTH:1]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DIV_RUN: begin
        work_d = trial[WIDTH] ? div_shift : {trial, div_shift[WIDTH-1:1], 1'b1};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        work_d  = {1'b0, fix_r, fix_q};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (zero_q) begin
          div_done_d = 1'b1;
          dz_d       = 1'b1;
        end else if (is_div_q) begin
          hi_d       = work_q[2*WIDTH-1:WIDTH];
          lo_d       = work_q[WIDTH-1:0];
          div_done_d = 1'b1;
        end else begin
          hi_d        = work_q[RW-1:WIDTH+1];
          lo_d        = work_q[WIDTH:1];
          mult_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      opnd_q      <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      is_div_q    <= 1'b0;
      zero_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      mult_done_q <= 1'b0;
      div_done_q  <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      opnd_q      <= opnd_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      is_div_q    <= is_div_d;
      zero_q      <= zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mult_done_q <= mult_done_d;
      div_done_q  <= div_done_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mult_done   = mult_done_q;
  assign div_done    = div_done_q;
  assign div_by_zero = dz_q;
  assign busy        = busy_q;

endmodule
